multiword_add_sequencer: RTL and testbench
==========================================

// Module: multiword_add_sequencer
// PURPOSE
//  Adds two WIDTH-bit operands using one SLICE-bit ripple-carry adder slice
//  (SLICE full adders in a chain) reused over WIDTH/SLICE cycles, LSB slice first.
//  Sits between an operand producer and a result consumer, with valid/ready on both sides.
//  Trades latency for area: one narrow adder serves arbitrarily wide operands.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be a multiple of SLICE
//  SLICE   4  bits added per cycle (width of the internal ripple adder slice)
//  (N = WIDTH/SLICE slices per operation; index counter is clog2(N) bits, min 1)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand request valid
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  a          in   WIDTH  operand A, sampled on accept
//  b          in   WIDTH  operand B, sampled on accept
//  cin        in   1      carry-in, sampled on accept
//  out_valid  out  1      result valid (high only in DONE)
//  out_ready  in   1      consumer accepts the result
//  sum        out  WIDTH  a + b + cin, modulo 2^WIDTH
//  cout       out  1      carry out of bit WIDTH-1
//  ovf        out  1      signed overflow = carry into MSB XOR carry out of MSB
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  Reset (rst_n low, async): state=IDLE, idx=0, sum=0, cout=0, ovf=0, carry reg=0,
//   out_valid=0, busy=0; in_ready=1 (combinational from IDLE); inputs ignored while low.
//  FSM states IDLE, RUN, DONE; outputs in_ready/out_valid/busy decoded from state.
//  IDLE: accept when in_valid & in_ready at a rising edge -> latch a, b into operand
//   shift registers, carry<=cin, idx<=0, state->RUN. in_valid without accept: no change.
//  RUN: each edge adds slice idx = {a[SLICE-1:0], b[SLICE-1:0], carry}; result slice
//   shifted into sum from MSB end, operands shift right by SLICE, carry<=slice carry-out,
//   idx<=idx+1. On the edge where idx==N-1: cout<=slice carry-out,
//   ovf<=slice carry into its MSB XOR slice carry-out, state->DONE.
//  Latency: accept at edge E0 -> out_valid high after edge E0+N (N=4 at defaults).
//  DONE: sum/cout/ovf held stable while out_valid=1 and out_ready=0 (unlimited backpressure).
//   Handshake out_valid & out_ready at an edge -> state->IDLE; sum/cout/ovf keep last values.
//  No accept while busy: in_ready=0 in RUN/DONE; in_valid then has no effect.
//  Min throughput: one operation per N+2 cycles (accept, N RUN edges, DONE handshake).
//  sum bits are undefined-free: partially filled sum is not visible because out_valid=0
//   until DONE; verifier checks sum only when out_valid=1.
//  Reset mid-RUN or mid-DONE: immediate return to reset values; pending operation lost.
//  N==1 (WIDTH==SLICE): RUN lasts one edge; idx held at 0.
//  Carry ripple across slice boundaries is via the carry register only.
// TESTING (WIDTH=16, SLICE=4)
//  0x1234+0x4321, cin=0 -> out_valid after 4 edges, sum=0x5555, cout=0, ovf=0
//  0xFFFF+0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0 (carry through all slices)
//  0x7FFF+0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; 0x8000+0x8000 -> 0x0000, cout=1, ovf=1
//  Hold out_ready=0 for 10 cycles in DONE, pulse in_valid -> sum/cout stable, in_ready=0, no accept
//  Assert rst_n=0 at 2nd RUN edge -> out_valid=0, sum=0, in_ready=1; next op 0x0F0F+0x00F1 -> 0x1000
//  Back-to-back with in_valid & out_ready tied high, 20 random ops -> each result matches a+b+cin

Source files
------------

// File: rtl/multiword_add_sequencer.sv
// Multi-cycle adder: one SLICE-bit ripple slice reused WIDTH/SLICE times, LSB slice first,
// with valid/ready handshakes on the operand and result sides.
module multiword_add_sequencer #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int N  = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Returns {carry into slice MSB, slice carry-out, slice sum}.
  function automatic logic [SLICE+1:0] slice_add(input logic [SLICE-1:0] x,
                                                 input logic [SLICE-1:0] y,
                                                 input logic             c);
    logic [SLICE:0]   c_v;
    logic [SLICE-1:0] s_v;
    c_v    = {(SLICE+1){1'b0}};
    s_v    = {SLICE{1'b0}};
    c_v[0] = c;
    for (int i = 0; i < SLICE; i++) begin
      s_v[i]   = x[i] ^ y[i] ^ c_v[i];
      c_v[i+1] = (x[i] & y[i]) | (x[i] & c_v[i]) | (y[i] & c_v[i]);
    end
    return {c_v[SLICE-1], c_v[SLICE], s_v};
  endfunction

  state_t           state_r;
  logic [IW-1:0]    idx_r;
  logic [WIDTH-1:0] opa_r;
  logic [WIDTH-1:0] opb_r;
  logic             carry_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;

  logic [SLICE+1:0] slice_s;
  logic [SLICE-1:0] slice_sum_s;
  logic             slice_cout_s;
  logic             slice_cmsb_s;
  logic             last_s;
  logic [WIDTH-1:0] sum_next_s;

  // Current slice addition and last-slice detection.
  always_comb begin
    slice_s      = slice_add(opa_r[SLICE-1:0], opb_r[SLICE-1:0], carry_r);
    slice_sum_s  = slice_s[SLICE-1:0];
    slice_cout_s = slice_s[SLICE];
    slice_cmsb_s = slice_s[SLICE+1];
    last_s       = (idx_r == IW'(N - 1));
  end

  // Result slices enter from the MSB end so the LSB slice lands at bit 0 after N steps.
  if (N > 1) begin : g_multi
    assign sum_next_s = {slice_sum_s, sum_r[WIDTH-1:SLICE]};
  end else begin : g_single
    assign sum_next_s = slice_sum_s;
  end

  // Control FSM with operand/result datapath and registered handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      idx_r       <= {IW{1'b0}};
      opa_r       <= {WIDTH{1'b0}};
      opb_r       <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      sum_r       <= {WIDTH{1'b0}};
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            opa_r      <= a;
            opb_r      <= b;
            carry_r    <= cin;
            idx_r      <= {IW{1'b0}};
            state_r    <= RUN;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        RUN: begin
          sum_r   <= sum_next_s;
          opa_r   <= opa_r >> SLICE;
          opb_r   <= opb_r >> SLICE;
          carry_r <= slice_cout_s;
          if (last_s) begin
            cout_r      <= slice_cout_s;
            ovf_r       <= slice_cmsb_s ^ slice_cout_s;
            idx_r       <= {IW{1'b0}};
            state_r     <= DONE;
            out_valid_r <= 1'b1;
          end else begin
            idx_r <= idx_r + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          idx_r       <= {IW{1'b0}};
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Self-checking bench for multiword_add_sequencer: directed vectors, backpressure,
// mid-operation reset and a randomized back-to-back stream against an arithmetic model.
module tb_multiword_add_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  multiword_add_sequencer #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Reference: {ovf, cout, sum} from plain integer arithmetic and sign rules.
  function automatic logic [17:0] ref_add(input logic [15:0] x, input logic [15:0] y,
                                          input logic c);
    logic [16:0] t;
    logic        v;
    t = {1'b0, x} + {1'b0, y} + {16'd0, c};
    v = (x[15] == y[15]) && (t[15] != x[15]);
    return {v, t};
  endfunction

  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tc);
    logic [17:0] e;
    int lat;
    e = ref_add(ta, tb_v, tc);
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
    check({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_sum"}, sum, e[15:0]);
    check({tag, "_cout"}, cout, e[16]);
    check({tag, "_ovf"}, ovf, e[17]);
    check({tag, "_busy"}, busy, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_released"}, {out_valid, in_ready, busy}, 3'b010);
  endtask

  initial begin
    logic [17:0] e;
    logic [17:0] q[$];
    logic [15:0] held;
    int issued, received, cyc;

    rst_n = 1'b0; in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b1; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_flags", {in_ready, out_valid, busy}, 3'b100);
    check("reset_result", {cout, ovf, sum}, 18'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {in_ready, busy}, 2'b10);

    run_op("v1", 16'h1234, 16'h4321, 1'b0);
    run_op("v2", 16'hFFFF, 16'h0000, 1'b1);
    run_op("v3", 16'h7FFF, 16'h0001, 1'b0);
    run_op("v4", 16'h8000, 16'h8000, 1'b0);

    // Backpressure: result held while out_ready low, in_valid ignored.
    e = ref_add(16'h9ABC, 16'h1357, 1'b1);
    @(negedge clk);
    a = 16'h9ABC; b = 16'h1357; cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("bp_valid", out_valid, 1);
    held = sum;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 4) || (i == 5);
      a = 16'h0101; b = 16'h0202; cin = 1'b0;
      @(negedge clk);
      check("bp_in_ready", {in_ready, out_valid}, 2'b01);
    end
    in_valid = 1'b0;
    check("bp_sum_stable", held, e[15:0]);
    check("bp_sum", sum, e[15:0]);
    check("bp_cout_ovf", {cout, ovf}, {e[16], e[17]});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("bp_no_accept", {busy, in_ready, out_valid}, 3'b010);

    // Reset in the middle of RUN.
    @(negedge clk);
    a = 16'hDEAD; b = 16'hBEEF; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("midrun_reset", {out_valid, in_ready, busy, sum}, {3'b010, 16'h0000});
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_reset", 16'h0F0F, 16'h00F1, 1'b0);

    // Back-to-back random stream with in_valid and out_ready held high.
    issued = 0; received = 0; cyc = 0;
    out_ready = 1'b1;
    while (received < 20 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        if (q.size() == 0) begin
          check("b2b_unexpected", 1, 0);
        end else begin
          e = q.pop_front();
          check("b2b_result", {ovf, cout, sum}, {e[17], e[16], e[15:0]});
        end
        received++;
      end
      if (issued < 20) begin
        in_valid = 1'b1;
        if (in_ready) begin
          a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
          q.push_back(ref_add(a, b, cin));
          issued++;
        end else begin
          a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    check("b2b_count", received, 20);
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
